// File: rtl/lem_world_if.sv
// lem_world_if: walker <-> world link.
//   walk_left, walk_right, aaah : driven by the walker FSM (master)
//   bump_left, bump_right, ground : driven by the world model (slave)
interface lem_world_if;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic bump_left;
  logic bump_right;
  logic ground;

  modport master (
    output walk_left,
    output walk_right,
    output aaah,
    input  bump_left,
    input  bump_right,
    input  ground
  );

  modport slave (
    input  walk_left,
    input  walk_right,
    input  aaah,
    output bump_left,
    output bump_right,
    output ground
  );
endinterface

// File: rtl/lem_world.sv
// lem_world: environment model for the lemming walker FSM.
// Tracks the lemming's tile in a 1-D level, holds a loadable hole map,
// runs fixed-length falls, fills a hole on landing and counts falls.
// Ports:
//   clk         rising-edge clock
//   areset_n    asynchronous active-low reset
//   load        synchronous terrain load strobe (also restarts at START_POS)
//   hole_map    terrain to load, bit i = 1 means tile i is a hole
//   walker      lem_world_if.slave: walk/aaah in, bump/ground out
//   pos         current tile
//   land        one-cycle pulse on the cycle after a fall completes
//   falls_total completed falls, saturating at 255
module lem_world #(
  parameter int WIDTH     = 16,
  parameter int POS_W     = 4,
  parameter int START_POS = 8,
  parameter int FALL_CYC  = 3
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] hole_map,
  lem_world_if.slave       walker,
  output logic [POS_W-1:0] pos,
  output logic             land,
  output logic [7:0]       falls_total
);

  localparam int FT_W = (FALL_CYC > 1) ? $clog2(FALL_CYC) : 1;
  localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);
  localparam logic [POS_W-1:0] LAST_P  = POS_W'(WIDTH - 1);
  localparam logic [FT_W-1:0]  FT_LAST = FT_W'(FALL_CYC - 1);

  logic [POS_W-1:0] pos_reg,     pos_next;
  logic [WIDTH-1:0] terrain_reg, terrain_next;
  logic [FT_W-1:0]  fall_t_reg,  fall_t_next;
  logic             land_reg,    land_next;
  logic [7:0]       falls_reg,   falls_next;

  logic ground_w;
  logic fall_done;
  // aaah is informational only: fall timing is owned by the terrain.
  logic aaah_unused;

  assign aaah_unused = walker.aaah;

  // Outputs to the walker decode registers only, so the loop through the
  // Moore walker has no combinational path.
  assign ground_w          = ~terrain_reg[pos_reg];
  assign fall_done         = ~ground_w & (fall_t_reg == FT_LAST);
  assign walker.ground     = ground_w;
  assign walker.bump_left  = (pos_reg == '0);
  assign walker.bump_right = (pos_reg == LAST_P);

  assign pos         = pos_reg;
  assign land        = land_reg;
  assign falls_total = falls_reg;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pos_reg     <= START_P;
      terrain_reg <= '0;
      fall_t_reg  <= '0;
      land_reg    <= 1'b0;
      falls_reg   <= 8'd0;
    end else begin
      pos_reg     <= pos_next;
      terrain_reg <= terrain_next;
      fall_t_reg  <= fall_t_next;
      land_reg    <= land_next;
      falls_reg   <= falls_next;
    end
  end

  // Priority: load, then falling, then walking.
  always_comb begin
    pos_next    = pos_reg;
    fall_t_next = fall_t_reg;
    land_next   = 1'b0;
    falls_next  = falls_reg;
    if (load) begin
      pos_next    = START_P;
      fall_t_next = '0;
    end else if (!ground_w) begin
      if (fall_done) begin
        fall_t_next = '0;
        land_next   = 1'b1;
        if (falls_reg != 8'hFF) begin
          falls_next = falls_reg + 8'd1;
        end
      end else begin
        fall_t_next = fall_t_reg + 1'b1;
      end
    end else begin
      fall_t_next = '0;
      if (walker.walk_left && !walker.walk_right && (pos_reg != '0)) begin
        pos_next = pos_reg - 1'b1;
      end else if (walker.walk_right && !walker.walk_left && (pos_reg != LAST_P)) begin
        pos_next = pos_reg + 1'b1;
      end
    end
  end

  // Per-tile terrain update: a load overwrites everything, otherwise only
  // the tile under a completed fall is filled.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tile
      always_comb begin
        terrain_next[gi] = terrain_reg[gi];
        if (load) begin
          terrain_next[gi] = hole_map[gi];
        end else if (fall_done && (pos_reg == POS_W'(gi))) begin
          terrain_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: doc/lem_world.md
# lem_world

Environment model for the lemming walker FSM. It tracks the lemming's tile position in a 1-D level of `WIDTH` tiles and holds a loadable hole map. From that state it drives `bump_left`, `bump_right` and `ground` into the walker, and consumes the walker's `walk_left`, `walk_right` and `aaah` outputs. Landing from a fall fills the hole, and completed falls are counted.

## Interface

Parameters:
- `WIDTH`, 16: number of tiles. Tile 0 is the left wall edge; tile `WIDTH-1` is the right wall edge.
- `POS_W`, 4: position width. Requires `WIDTH <= 2**POS_W`.
- `START_POS`, 8: tile after reset or load. Requires `START_POS < WIDTH`.
- `FALL_CYC`, 3: cycles `ground` stays low per fall. Requires `FALL_CYC >= 1`.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  synchronous terrain load strobe.
- `hole_map`  in  `WIDTH`  terrain to load; bit i = 1 means tile i is a hole.
- `walk_left`  in  1  from walker FSM.
- `walk_right`  in  1  from walker FSM.
- `aaah`  in  1  from walker FSM (falling).
- `bump_left`  out  1  to walker.
- `bump_right`  out  1  to walker.
- `ground`  out  1  to walker.
- `pos`  out  `POS_W`  current tile.
- `land`  out  1  one-cycle pulse on the cycle after a fall completes.
- `falls_total`  out  8  completed falls, saturates at 255.

## Operation

Registers:
- `pos`
- `terrain[WIDTH-1:0]`
- `fall_t`, a counter from 0 to `FALL_CYC-1`
- `land`
- `falls_total`

Combinational outputs, decoded from registers only:
- `bump_left` = (`pos` == 0)
- `bump_right` = (`pos` == `WIDTH-1`)
- `ground` = ~`terrain[pos]`

Per-edge update, in priority order:
1. **`load` = 1:**
   - `terrain` <= `hole_map`
   - `pos` <= `START_POS`
   - `fall_t` <= 0
   - `land` <= 0
   - `falls_total` is held.
2. **`ground` = 0 (falling):**
   - `pos` is held; walk inputs are ignored.
   - If `fall_t` == `FALL_CYC-1`:
     - `terrain[pos]` <= 0 (hole filled)
     - `fall_t` <= 0
     - `land` <= 1
     - `falls_total` <= sat(+1)
   - Else: `fall_t` <= `fall_t`+1 and `land` <= 0.
3. **`ground` = 1 (walking):**
   - `land` <= 0 and `fall_t` <= 0.
   - `walk_left` & ~`walk_right` & `pos` != 0: `pos` <= `pos`-1.
   - `walk_right` & ~`walk_left` & `pos` != `WIDTH-1`: `pos` <= `pos`+1.
   - Both walk inputs high, neither high, or pushing into a wall edge: `pos` is held.

Further rules:
- `aaah` is informational only. Fall timing is owned by `terrain`, not by `aaah`.
- Stepping onto a hole tile drops `ground` combinationally in the same cycle `pos` changes.
- Tile `START_POS` marked as a hole in `hole_map`: the fall begins immediately after `load`. This is legal.
- Hole at tile 0 or at tile `WIDTH-1`: `bump_*` and `ground`=0 are asserted together. The walker's fall priority resolves this; no special handling here.

## Timing

Reset values while `areset_n` = 0, applied asynchronously:
- `pos` = `START_POS`
- `terrain` = 0, so `ground` = 1
- `fall_t` = 0
- `land` = 0
- `falls_total` = 0
- `bump_left` = (`START_POS`==0)
- `bump_right` = (`START_POS`==`WIDTH-1`)

Release of `areset_n` is synchronised by the integrator, not by this block.

Latency:
- Walk input to `pos` change: one edge.
- `pos` to `bump_*`/`ground`: combinational.

Loop closure:
- The walker registers its state on the same edge. A step onto a hole therefore shows `aaah` one cycle after `pos` updates.
- There is no combinational loop, because the walker outputs are Moore outputs.

Fall timing:
- `ground` is low for exactly `FALL_CYC` consecutive cycles per hole.
- `land` is high for the single cycle in which `ground` returns to 1.

Mid-operation events:
- `load` mid-fall aborts the fall: no `land` pulse and no count increment.
- `areset_n` assertion mid-fall returns all registers to their reset values within the same cycle.

Saturation:
- `falls_total` stays at 255.

## Test plan

- **Reset and walk left:** assert `areset_n`=0, release, drive `walk_left`=1 for 8 edges.
  - Required: `pos` 8→0.
  - Required: `bump_left`=1 once `pos`=0.
  - Required: a 9th edge holds `pos`=0.
- **Walk right to the right wall edge:** from `pos`=0, drive `walk_right`=1 for 16 edges.
  - Required: `pos` reaches 15 and holds.
  - Required: `bump_right`=1 and `bump_left`=0.
- **Fall and land:** `load` `hole_map`=16'h0200 (tile 9), then `walk_right`=1.
  - Required: `pos`=9 with `ground`=0 for exactly 3 cycles while `pos` holds at 9.
  - Required: then `ground`=1, `land`=1 for 1 cycle, `falls_total`=1, `terrain[9]`=0.
  - Required: walking back over tile 9 keeps `ground`=1.
- **Abort on load:** load `hole_map`=16'h0100 (the start tile), wait 1 cycle, then pulse `load` again with 16'h0000.
  - Required: `ground` returns to 1, `pos`=8.
  - Required: no `land` pulse and `falls_total` unchanged.
- **Conflicting walk inputs and saturation:** drive `walk_left`=`walk_right`=1.
  - Required: `pos` holds.
  - Then run 256 fall cycles, reloading `hole_map`=16'h0100 after each `land` pulse, and check `falls_total` saturates at 255.
- **Reset mid-fall:** pulse `areset_n` low during the second fall cycle.
  - Required: immediately `pos`=8, `ground`=1, `land`=0, `falls_total`=0.
